// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_INC = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  read_ok;
    logic                  write_ok;

    // The extra wrap bit separates full (same index, different lap) from empty.
    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

    assign read_ok  = r_en && !empty;
    assign write_ok = w_en && (!full || read_ok);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            data_out <= '0;
        end else begin
            if (write_ok) begin
                wptr <= wptr + PTR_INC;
            end
            if (read_ok) begin
                data_out <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr     <= rptr + PTR_INC;
            end
        end
    end

    // Storage is never cleared; reset only blocks the write in its own cycle.
    always_ff @(posedge clk) begin
        if (rst && write_ok) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full && !read_ok) begin
                overflow <= 1'b1;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: ordering, flags, wrap, reset.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_sync_fifo;

    logic        clk;
    logic        rst;
    logic        w_en;
    logic        r_en;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        full;
    logic        empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic        overflow;
    logic        underflow;
`endif

    int checks = 0;
    int errors = 0;

    sync_fifo #(.DATA_WIDTH(32), .DEPTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst_v, input logic w, input logic r,
                                 input logic [31:0] d);
        @(negedge clk);
        rst     = rst_v;
        w_en    = w;
        r_en    = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] exp_data,
                               input logic exp_empty, input logic exp_full);
        checks++;
        assert (data_out === exp_data) else begin
            errors++;
            $error("[TB] FAIL %s data_out got %h expected %h", tag, data_out, exp_data);
        end
        checks++;
        assert (empty === exp_empty) else begin
            errors++;
            $error("[TB] FAIL %s empty got %b expected %b", tag, empty, exp_empty);
        end
        checks++;
        assert (full === exp_full) else begin
            errors++;
            $error("[TB] FAIL %s full got %b expected %b", tag, full, exp_full);
        end
    endtask

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    task automatic checkErrFlags(input string tag, input logic exp_ovf, input logic exp_udf);
        checks++;
        assert (overflow === exp_ovf) else begin
            errors++;
            $error("[TB] FAIL %s overflow got %b expected %b", tag, overflow, exp_ovf);
        end
        checks++;
        assert (underflow === exp_udf) else begin
            errors++;
            $error("[TB] FAIL %s underflow got %b expected %b", tag, underflow, exp_udf);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = '0;

        // Reset, then an idle cycle
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h1234_5678);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("reset_idle", 32'h0, 1'b1, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checkErrFlags("reset_err", 1'b0, 1'b0);
`endif

        // Single write then read
        applyStimulus(1'b1, 1'b1, 1'b0, 32'hA000_0000);
        checkOutput("single_wr", 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("single_rd", 32'hA000_0000, 1'b1, 1'b0);

        // Five writes, then five simultaneous write+read
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'hA000_0000 + i);
            checkOutput("prefill", 32'hA000_0000, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 32'hA000_000A + i);
            checkOutput("simul_rw", 32'hA000_0000 + i, 1'b0, 1'b0);
        end

        // Reset then fill all 32 entries, then drain
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("reset2", 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'hA000_0000 + i);
            checkOutput("fill", 32'h0, 1'b0, (i == 31));
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
            checkOutput("drain", 32'hA000_0000 + i, (i == 31), 1'b0);
        end

        // Fill again (wrapped pointers), write while full is dropped
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'hA000_0000 + i);
        end
        checkOutput("refill", 32'hA000_001F, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        checkOutput("wr_full", 32'hA000_001F, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
            checkOutput("drain_ovf", 32'hA000_0000 + i, (i == 31), 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("rd_empty", 32'hA000_001F, 1'b1, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checkErrFlags("err_sticky", 1'b1, 1'b1);
`endif

        // Simultaneous write+read while full
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'hB000_0000 + i);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hC000_0000);
        checkOutput("rw_full", 32'hB000_0000, 1'b0, 1'b1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checkErrFlags("rw_full_err", 1'b0, 1'b0);
`endif
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
            checkOutput("drain_rw", 32'hB000_0000 + i, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("drain_last", 32'hC000_0000, 1'b1, 1'b0);

        // Reset mid-operation discards contents
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'hE000_0000 + i);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("partial", 32'hE000_0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h5555_5555);
        checkOutput("mid_reset", 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'hD000_0000);
        checkOutput("post_rst_wr", 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("post_rst_rd", 32'hD000_0000, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
